// File: rtl/like_alu.sv
// Registered 4-function ALU (ADD/SUB/AND/OR) with carry/borrow and zero flags.
// Single-cycle latency; synchronous active-high reset clears all outputs.
module like_alu #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res_d;
  logic             cy_d;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res_d = '0;
    cy_d  = 1'b0;
    case (select)
      2'b00: begin res_d = sum[WIDTH-1:0];  cy_d = sum[WIDTH];  end
      // borrow out of the extended subtraction is exactly a < b
      2'b01: begin res_d = diff[WIDTH-1:0]; cy_d = diff[WIDTH]; end
      2'b10: res_d = a & b;
      2'b11: res_d = a | b;
      default: ;
    endcase
  end

  // zero tracks the value being loaded, not the one currently held
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
    end else begin
      result <= res_d;
      carry  <= cy_d;
      zero   <= (res_d == '0);
    end
  end

endmodule

// File: tb/tb_like_alu.sv
// Bench for like_alu: directed vectors with literal expectations, plus an
// arithmetic reference model compared against the outputs every cycle.
module tb_like_alu;
  localparam int W = 5;
  localparam int M = 2 ** W;

  logic         clk = 1'b0, rst = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic [1:0]   select = '0;
  logic [W-1:0] result;
  logic         carry, zero;

  int errors = 0, checks = 0;
  int m_r = 0, m_c = 0, m_z = 0;
  bit m_valid = 0;

  like_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .select(select),
    .result(result), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  // reference model: plain integer arithmetic on the sampled inputs
  always @(posedge clk) begin
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (rst) begin
      m_r = 0; m_c = 0; m_z = 0;
    end else begin
      case (int'(select))
        0: begin m_r = (ia + ib) % M;     m_c = (ia + ib >= M) ? 1 : 0; end
        1: begin m_r = (ia - ib + M) % M; m_c = (ia < ib) ? 1 : 0;      end
        2: begin m_r = ia & ib;           m_c = 0;                      end
        default: begin m_r = ia | ib;     m_c = 0;                      end
      endcase
      m_z = (m_r == 0) ? 1 : 0;
    end
    m_valid = 1;
  end

  // mid-cycle compare also confirms outputs hold between edges
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (result !== m_r[W-1:0] || carry !== m_c[0] || zero !== m_z[0]) begin
        errors++;
        $display("FAIL model t=%0t: got r=%b c=%b z=%b, want r=%b c=%0d z=%0d",
                 $time, result, carry, zero, m_r[W-1:0], m_c, m_z);
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] er, input logic ec, input logic ez);
    checks++;
    if (result !== er || carry !== ec || zero !== ez) begin
      errors++;
      $display("FAIL %s: got r=%b c=%b z=%b, want r=%b c=%b z=%b",
               name, result, carry, zero, er, ec, ez);
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [1:0] s);
    @(negedge clk); #1;
    rst = r; a = va; b = vb; select = s;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset", 5'b00000, 1'b0, 1'b0);

    step(0, 5'b01010, 5'b10101, 2'b00); chk("add",      5'b11111, 1'b0, 1'b0);
    step(0, 5'b00101, 5'b11110, 2'b01); chk("sub",      5'b00111, 1'b1, 1'b0);
    step(0, 5'b01011, 5'b10100, 2'b10); chk("and",      5'b00000, 1'b0, 1'b1);
    step(0, 5'b01001, 5'b01010, 2'b11); chk("or",       5'b01011, 1'b0, 1'b0);
    step(0, 5'b11111, 5'b00001, 2'b00); chk("wrap",     5'b00000, 1'b1, 1'b1);
    step(0, 5'b00000, 5'b00001, 2'b01); chk("sub0m1",   5'b11111, 1'b1, 1'b0);
    step(0, 5'b10110, 5'b10110, 2'b01); chk("sub_eq",   5'b00000, 1'b0, 1'b1);
    step(0, 5'b10000, 5'b10000, 2'b00); chk("add_c0",   5'b00000, 1'b1, 1'b1);
    step(0, 5'b11100, 5'b00111, 2'b11); chk("or_hi",    5'b11111, 1'b0, 1'b0);

    // reset over a nonzero result, then release with the ADD vector
    step(1, 5'b11111, 5'b00001, 2'b00); chk("rst_mid",  5'b00000, 1'b0, 1'b0);
    step(0, 5'b01010, 5'b10101, 2'b00); chk("rst_rel",  5'b11111, 1'b0, 1'b0);

    // reset pulse entirely between edges must be ignored
    @(negedge clk); #1;
    a = 5'b00011; b = 5'b00100; select = 2'b11; rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_glitch", 5'b00111, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      a = W'($urandom_range(0, M - 1));
      b = W'($urandom_range(0, M - 1));
      select = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/like_alu.md
LIKE_ALU -- requirements
Module: like_alu

Interface
REQ-001 Parameter WIDTH, default 5, operand and result width in bits; all requirements below use the default.
REQ-002 clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 a  input  WIDTH  operand A, unsigned.
REQ-005 b  input  WIDTH  operand B, unsigned.
REQ-006 select  input  2  operation code.
REQ-007 result  output  WIDTH  registered operation result.
REQ-008 carry  output  1  registered carry/borrow flag.
REQ-009 zero  output  1  registered flag, 1 when the registered result equals 0.

Function
REQ-010 The block SHALL compute the operation combinationally from a, b and select, and register it on each rising edge of clk when rst=0.
REQ-011 Latency SHALL be exactly 1 clock: inputs sampled at edge N appear on result/carry/zero after edge N.
REQ-012 Outputs SHALL hold their values between edges; there is no enable or handshake, and every edge loads new values.
REQ-013 select=00 ADD: result = (a + b) mod 2^WIDTH; carry = bit WIDTH of the full (WIDTH+1)-bit sum.
REQ-014 select=01 SUB: result = (a - b) mod 2^WIDTH, two's-complement wrap; carry = 1 when a < b (borrow), otherwise 0.
REQ-015 select=10 AND: result = a AND b bitwise; carry = 0.
REQ-016 select=11 OR: result = a OR b bitwise; carry = 0.
REQ-017 zero SHALL be derived from the newly computed result value in the same cycle it is registered, never from the previous result.
REQ-018 Boundaries: 31+1 -> result 00000, carry 1, zero 1; 0-1 -> result 11111, carry 1; a=b under SUB -> result 0, carry 0, zero 1.
REQ-019 No X/Z SHALL propagate to the outputs for fully-defined inputs, and every select code SHALL be decoded (no default-to-X case).

Reset
REQ-020 When rst=1 at a rising edge, result SHALL become 00000, carry 0 and zero 0, regardless of a, b and select.
REQ-021 Reset asserted mid-operation SHALL discard the in-flight computation; the first edge with rst=0 registers the current inputs normally.
REQ-022 Asserting rst between edges SHALL have no effect until the next rising edge.

Verification
REQ-023 ADD: a=01010, b=10101, select=00, one edge -> result 11111, carry 0, zero 0.
REQ-024 SUB: a=00101, b=11110, select=01 -> result 00111, carry 1, zero 0.
REQ-025 AND: a=01011, b=10100, select=10 -> result 00000, carry 0, zero 1.
REQ-026 OR: a=01001, b=01010, select=11 -> result 01011, carry 0, zero 0.
REQ-027 Wrap: a=11111, b=00001, select=00 -> result 00000, carry 1, zero 1.
REQ-028 Reset: after any nonzero result, rst=1 for one edge -> result 00000, carry 0, zero 0; releasing rst with the REQ-023 inputs gives 11111 one edge later.
